// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter for the shared pipelined SRAM user port.
// Port 0 is the host/USB-side logic and port 1 is the generated fabric logic.
// Read results come back to the port that issued them, in order, through a
// 1-bit tag FIFO.
module sram_port_arbiter #(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 18,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          p0_a,
    input  logic                       p0_w,
    input  logic                       p0_r,
    input  logic [DATA_W-1:0]          p0_dw,
    output logic                       p0_gnt,
    output logic [DATA_W-1:0]          p0_dr,
    output logic                       p0_dr_valid,
    input  logic [ADDR_W-1:0]          p1_a,
    input  logic                       p1_w,
    input  logic                       p1_r,
    input  logic [DATA_W-1:0]          p1_dw,
    output logic                       p1_gnt,
    output logic [DATA_W-1:0]          p1_dr,
    output logic                       p1_dr_valid,
    output logic [ADDR_W-1:0]          sram_a,
    output logic                       sram_w,
    output logic                       sram_r,
    output logic [DATA_W-1:0]          sram_dw,
    input  logic [DATA_W-1:0]          sram_dr,
    input  logic                       sram_dr_valid,
    output logic [$clog2(TAG_DEPTH):0] outstanding,
    output logic                       err_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tag_mem [TAG_DEPTH];

    logic full, empty;
    logic p0_rd, p1_rd;
    logic p0_elig, p1_elig;
    logic gnt0, gnt1;
    logic grant_any, grant_rd;
    logic push, pop, head;
    logic last_grant;

    assign full  = (count == CNT_W'(TAG_DEPTH));
    assign empty = (count == '0);

    // A simultaneous write+read request is a write.
    assign p0_rd = p0_r & ~p0_w;
    assign p1_rd = p1_r & ~p1_w;

    // Grants are held off while reset is asserted so every output reads 0.
    assign p0_elig = rst_n & (p0_w | (p0_rd & ~full));
    assign p1_elig = rst_n & (p1_w | (p1_rd & ~full));

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (p0_elig && p1_elig) begin
            if (last_grant) gnt0 = 1'b1;
            else            gnt1 = 1'b1;
        end else begin
            gnt0 = p0_elig;
            gnt1 = p1_elig;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign grant_any = gnt0 | gnt1;
    assign grant_rd  = (gnt0 & p0_rd) | (gnt1 & p1_rd);
    assign push      = grant_rd;
    assign pop       = sram_dr_valid & ~empty;
    assign head      = tag_mem[rd_ptr];
    assign outstanding = count;

    // Remember the most recent winner for the tie-break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         last_grant <= 1'b1;
        else if (grant_any) last_grant <= gnt1;
    end

    // Registered command issue; strobes pulse one cycle, address/data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a  <= '0;
            sram_dw <= '0;
            sram_w  <= 1'b0;
            sram_r  <= 1'b0;
        end else begin
            sram_w <= gnt0 ? p0_w : (gnt1 & p1_w);
            sram_r <= grant_rd;
            if (grant_any) begin
                sram_a  <= gnt1 ? p1_a  : p0_a;
                sram_dw <= gnt1 ? p1_dw : p0_dw;
            end
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage: records which port issued each read.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt1;
    end

    // Registered read return, steered by the FIFO head tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_dr       <= '0;
            p1_dr       <= '0;
            p0_dr_valid <= 1'b0;
            p1_dr_valid <= 1'b0;
        end else begin
            p0_dr_valid <= pop & ~head;
            p1_dr_valid <= pop & head;
            if (pop && !head) p0_dr <= sram_dr;
            if (pop && head)  p1_dr <= sram_dr;
        end
    end

    // Sticky flag for read data arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     err_orphan <= 1'b0;
        else if (sram_dr_valid && empty) err_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge, grants 1 ns after the falling edge.
module tb_sram_port_arbiter;

    localparam int ADDR_W    = 23;
    localparam int DATA_W    = 18;
    localparam int TAG_DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] p0_a, p1_a, sram_a;
    logic              p0_w, p0_r, p1_w, p1_r;
    logic [DATA_W-1:0] p0_dw, p1_dw, p0_dr, p1_dr, sram_dw, sram_dr;
    logic              p0_gnt, p1_gnt, p0_dr_valid, p1_dr_valid;
    logic              sram_w, sram_r, sram_dr_valid;
    logic [$clog2(TAG_DEPTH):0] outstanding;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_a         (p0_a),
        .p0_w         (p0_w),
        .p0_r         (p0_r),
        .p0_dw        (p0_dw),
        .p0_gnt       (p0_gnt),
        .p0_dr        (p0_dr),
        .p0_dr_valid  (p0_dr_valid),
        .p1_a         (p1_a),
        .p1_w         (p1_w),
        .p1_r         (p1_r),
        .p1_dw        (p1_dw),
        .p1_gnt       (p1_gnt),
        .p1_dr        (p1_dr),
        .p1_dr_valid  (p1_dr_valid),
        .sram_a       (sram_a),
        .sram_w       (sram_w),
        .sram_r       (sram_r),
        .sram_dw      (sram_dw),
        .sram_dr      (sram_dr),
        .sram_dr_valid(sram_dr_valid),
        .outstanding  (outstanding),
        .err_orphan   (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        p0_a = '0; p0_w = 1'b0; p0_r = 1'b0; p0_dw = '0;
        p1_a = '0; p1_w = 1'b0; p1_r = 1'b0; p1_dw = '0;
        sram_dr = '0; sram_dr_valid = 1'b0;
    endtask

    // Ends on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_sram_w", 32'(sram_w), 0);
        check("rst_sram_r", 32'(sram_r), 0);
        check("rst_sram_a", 32'(sram_a), 0);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_err_orphan", 32'(err_orphan), 0);
        check("rst_dr_valid", 32'({p0_dr_valid, p1_dr_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from port 0
        p0_a = 23'h00010; p0_w = 1'b1; p0_dw = 18'h2A5A1;
        #1;
        check("wr_p0_gnt", 32'(p0_gnt), 1);
        check("wr_p1_gnt", 32'(p1_gnt), 0);
        tick();
        check("wr_sram_w", 32'(sram_w), 1);
        check("wr_sram_r", 32'(sram_r), 0);
        check("wr_sram_a", 32'(sram_a), 32'h00010);
        check("wr_sram_dw", 32'(sram_dw), 32'h2A5A1);
        @(negedge clk);
        p0_w = 1'b0;
        tick();
        check("wr_sram_w_off", 32'(sram_w), 0);
        check("wr_sram_a_hold", 32'(sram_a), 32'h00010);

        // Tie alternation right after reset: p0 wins first
        do_reset();
        p0_a = 23'h00100; p0_w = 1'b1;
        p1_a = 23'h00200; p1_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_p0_gnt", 32'(p0_gnt), (i % 2 == 0) ? 1 : 0);
            check("tie_p1_gnt", 32'(p1_gnt), (i % 2 == 1) ? 1 : 0);
            tick();
            check("tie_sram_a", 32'(sram_a), (i % 2 == 0) ? 32'h00100 : 32'h00200);
            @(negedge clk);
        end
        p0_w = 1'b0; p1_w = 1'b0;

        // Read routing: p1 then p0, data returned in order
        do_reset();
        p1_r = 1'b1; p1_a = 23'h00100;
        #1;
        check("rd_p1_gnt", 32'(p1_gnt), 1);
        tick();
        check("rd_sram_r1", 32'(sram_r), 1);
        check("rd_sram_a1", 32'(sram_a), 32'h00100);
        check("rd_out_1", 32'(outstanding), 1);
        @(negedge clk);
        p1_r = 1'b0;
        p0_r = 1'b1; p0_a = 23'h00200;
        #1;
        check("rd_p0_gnt", 32'(p0_gnt), 1);
        tick();
        check("rd_sram_a2", 32'(sram_a), 32'h00200);
        check("rd_out_2", 32'(outstanding), 2);
        @(negedge clk);
        p0_r = 1'b0;
        tick();
        check("rd_sram_r_off", 32'(sram_r), 0);
        @(negedge clk);
        sram_dr_valid = 1'b1; sram_dr = 18'h11111;
        tick();
        check("rd_p1_dr_valid", 32'(p1_dr_valid), 1);
        check("rd_p0_dr_valid_a", 32'(p0_dr_valid), 0);
        check("rd_p1_dr", 32'(p1_dr), 32'h11111);
        check("rd_out_3", 32'(outstanding), 1);
        @(negedge clk);
        sram_dr = 18'h22222;
        tick();
        check("rd_p0_dr_valid", 32'(p0_dr_valid), 1);
        check("rd_p1_dr_valid_b", 32'(p1_dr_valid), 0);
        check("rd_p0_dr", 32'(p0_dr), 32'h22222);
        check("rd_p1_dr_hold", 32'(p1_dr), 32'h11111);
        check("rd_out_4", 32'(outstanding), 0);
        @(negedge clk);
        sram_dr_valid = 1'b0;
        tick();
        check("rd_p0_dr_valid_off", 32'(p0_dr_valid), 0);
        check("rd_no_orphan", 32'(err_orphan), 0);

        // FIFO full: 8 reads with SRAM stalled
        do_reset();
        p0_r = 1'b1;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            p0_a = 23'(i);
            #1;
            check("full_fill_gnt", 32'(p0_gnt), 1);
            tick();
            @(negedge clk);
        end
        check("full_out_8", 32'(outstanding), 8);
        p0_a = 23'h00009;
        p1_w = 1'b1; p1_a = 23'h00333;
        #1;
        check("full_p0_blocked", 32'(p0_gnt), 0);
        check("full_p1_write", 32'(p1_gnt), 1);
        tick();
        check("full_sram_w", 32'(sram_w), 1);
        check("full_sram_a", 32'(sram_a), 32'h00333);
        @(negedge clk);
        p1_w = 1'b0;
        sram_dr_valid = 1'b1; sram_dr = 18'h00003;
        #1;
        check("full_pop_no_gnt", 32'(p0_gnt), 0);
        tick();
        check("full_out_7", 32'(outstanding), 7);
        check("full_p0_dr_valid", 32'(p0_dr_valid), 1);
        check("full_p0_dr", 32'(p0_dr), 32'h00003);
        @(negedge clk);
        sram_dr_valid = 1'b0;
        #1;
        check("full_9th_gnt", 32'(p0_gnt), 1);
        tick();
        check("full_out_8b", 32'(outstanding), 8);
        check("full_9th_a", 32'(sram_a), 32'h00009);
        @(negedge clk);
        p0_r = 1'b0;

        // Orphan data with nothing outstanding
        do_reset();
        sram_dr_valid = 1'b1; sram_dr = 18'h3FFFF;
        tick();
        check("orph_flag", 32'(err_orphan), 1);
        check("orph_no_valid", 32'({p0_dr_valid, p1_dr_valid}), 0);
        @(negedge clk);
        sram_dr_valid = 1'b0;
        tick();
        tick();
        check("orph_sticky", 32'(err_orphan), 1);
        check("orph_out", 32'(outstanding), 0);

        // Reset with three reads in flight
        do_reset();
        p1_r = 1'b1; p1_a = 23'h00040;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
        end
        check("mid_out_3", 32'(outstanding), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_0", 32'(outstanding), 0);
        check("mid_gnt_off", 32'({p0_gnt, p1_gnt}), 0);
        check("mid_sram_r", 32'(sram_r), 0);
        check("mid_sram_a", 32'(sram_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        p1_r = 1'b0;
        @(negedge clk);
        sram_dr_valid = 1'b1; sram_dr = 18'h00555;
        tick();
        check("mid_orphan", 32'(err_orphan), 1);
        check("mid_no_valid", 32'({p0_dr_valid, p1_dr_valid}), 0);
        @(negedge clk);
        sram_dr_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the board's single pipelined SRAM user port (address, write strobe, read strobe, write data, read data, read-data-valid) between two requesters.
- Port 0 is the host/USB-side logic; port 1 is the generated fabric logic.
- Round-robin arbitration, at most one command issued per clock.
- Returns each read result to the requester that issued the read, using an in-order tag FIFO.

Parameters:
- ADDR_W, 23, SRAM word address width.
- DATA_W, 18, SRAM data width.
- TAG_DEPTH, 8, maximum outstanding reads; power of two, 2..16.

Ports:
- clk  in  1  system clock (user clock from the interfaces block)
- rst_n  in  1  asynchronous active-low reset
- p0_a  in  ADDR_W  port 0 address
- p0_w  in  1  port 0 write request
- p0_r  in  1  port 0 read request
- p0_dw  in  DATA_W  port 0 write data
- p0_gnt  out  1  port 0 command accepted this cycle
- p0_dr  out  DATA_W  port 0 read data
- p0_dr_valid  out  1  port 0 read data valid
- p1_a, p1_w, p1_r, p1_dw, p1_gnt, p1_dr, p1_dr_valid: same as port 0, for port 1
- sram_a  out  ADDR_W  to SRAM user address
- sram_w  out  1  to SRAM user write strobe
- sram_r  out  1  to SRAM user read strobe
- sram_dw  out  DATA_W  to SRAM user write data
- sram_dr  in  DATA_W  from SRAM user read data
- sram_dr_valid  in  1  from SRAM user read data valid
- outstanding  out  clog2(TAG_DEPTH)+1  reads in flight
- err_orphan  out  1  sticky: sram_dr_valid arrived with no read outstanding

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; tag FIFO emptied; outstanding=0; err_orphan=0.
  - Round-robin pointer set to last_grant=1, so port 0 wins the first tie.
- Request semantics:
  - A port requests when w|r is high and must hold a, w, r, dw stable until its gnt is high.
  - If w and r are both high, the command is treated as a write; r is ignored.
- Eligibility:
  - Writes are always eligible.
  - Reads are eligible only when the FIFO is not full, i.e. outstanding<TAG_DEPTH. A read popped in the same cycle does not free a slot until the next cycle.
- Arbitration (combinational, same cycle):
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port != last_grant.
  - last_grant updates on every grant.
  - p0_gnt and p1_gnt are never high together.
- Command issue: registered, one cycle after gnt.
  - sram_a, sram_dw, sram_w, sram_r are driven from the granted port.
  - sram_w and sram_r are single-cycle pulses and are 0 in any cycle following no grant.
  - sram_a and sram_dw hold their last value when idle.
- Tag FIFO:
  - Width 1 bit (port id), depth TAG_DEPTH, pointers wrap modulo TAG_DEPTH.
  - Push on a read grant, in the same edge as the registered issue.
  - Pop on sram_dr_valid.
  - Simultaneous push and pop leaves outstanding unchanged.
- Read return:
  - On sram_dr_valid with FIFO not empty, in the following cycle (1-cycle registered return) drive pX_dr=sram_dr and pX_dr_valid=1 for X = head tag. The other port's dr_valid is 0.
  - pX_dr holds its last value when valid is low.
  - Back-to-back sram_dr_valid is supported every cycle.
- Orphan data: sram_dr_valid with the FIFO empty (and no pop possible) sets err_orphan. The data is discarded and no dr_valid is produced. err_orphan clears only on reset.
- Latency:
  - Request to sram strobe: 1 cycle.
  - sram_dr_valid to pX_dr_valid: 1 cycle.
  - The SRAM's own read latency is opaque; ordering is in-order only.
- Reset mid-operation: in-flight reads are forgotten. Any later sram_dr_valid for them sets err_orphan.

Test Plan:
- Single write: p0 a=0x00010, w=1, dw=0x2A5A1 for one cycle -> p0_gnt=1 same cycle; next cycle sram_w=1, sram_a=0x00010, sram_dw=0x2A5A1; the cycle after, sram_w=0.
- Tie alternation: p0 and p1 both request writes continuously for 4 cycles after reset -> grants p0,p1,p0,p1; sram_a alternates p0_a/p1_a with 1-cycle lag.
- Read routing: p1 reads 0x00100 then p0 reads 0x00200; SRAM model returns 0x11111 and 0x22222 with latency 3 -> p1_dr_valid with 0x11111, then p0_dr_valid with 0x22222; outstanding goes 1,2,1,0.
- FIFO full: p0 issues 8 reads with the SRAM stalled -> outstanding=8; a 9th read gets no gnt; a p1 write is still granted. After one sram_dr_valid, the 9th read is granted the following cycle.
- Orphan: sram_dr_valid=1 with nothing outstanding -> err_orphan=1 persists; no pX_dr_valid.
- Reset mid-flight: 3 reads outstanding, pulse rst_n low -> outputs 0 and outstanding=0 immediately; later sram_dr_valid sets err_orphan.
